// File: rtl/hall_call_scheduler_if.sv
// Single-request link between the hall-call scheduler and the elevator car controller.
// The scheduler drives the request strobe; the car reports its position and door/idle status.
interface hall_call_scheduler_if;
   logic       valid_out;
   logic [2:0] req_floor;
   logic       direction;
   logic [2:0] car_floor;
   logic       door_open;
   logic       car_idle;

   modport master (
      output valid_out, req_floor, direction,
      input  car_floor, door_open, car_idle
   );

   modport slave (
      input  valid_out, req_floor, direction,
      output car_floor, door_open, car_idle
   );
endinterface

// File: rtl/hall_call_scheduler.sv
// Latches hall-call presses as pending requests and feeds them one at a time,
// round-robin, to the car controller; freezes and forgets issue history on emergency.
module hall_call_scheduler #(
   parameter int NUM_FLOORS = 8,
   parameter int ISSUE_GAP  = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_FLOORS-1:0]   hall_up_btn,
   input  logic [NUM_FLOORS-1:0]   hall_down_btn,
   input  logic                    emergency,
   output logic [NUM_FLOORS-1:0]   pending_up,
   output logic [NUM_FLOORS-1:0]   pending_down,
   output logic                    busy,
   hall_call_scheduler_if.master   car_if
);

   localparam int N_SRC = 2 * NUM_FLOORS;
   localparam int CW    = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_HOLD} state_t;

   state_t                  r_state, w_state_next;
   logic [NUM_FLOORS-1:0]   r_up_prev, r_dn_prev;
   logic [N_SRC-1:0]        r_pend, r_issued;
   logic [3:0]              r_ptr;
   logic [CW-1:0]           r_cnt;
   logic [2:0]              r_req_floor;
   logic                    r_dir;

   logic [NUM_FLOORS-1:0]   w_press_up, w_press_dn, w_clear_floor;
   logic [N_SRC-1:0]        w_clear, w_elig, w_set;
   logic [3:0]              w_sel_idx;
   logic                    w_sel_found, w_valid;

   // Top floor has no up button, ground floor has no down button.
   assign w_press_up = hall_up_btn   & ~r_up_prev & {1'b0, {(NUM_FLOORS-1){1'b1}}};
   assign w_press_dn = hall_down_btn & ~r_dn_prev & {{(NUM_FLOORS-1){1'b1}}, 1'b0};

   for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign w_clear_floor[gi] = (car_if.door_open | car_if.car_idle) &&
                                 (car_if.car_floor == 3'(gi));
   end

   assign w_clear = {w_clear_floor, w_clear_floor};
   assign w_elig  = r_pend & ~r_issued;

   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = r_ptr;
      for (int k = 0; k < N_SRC; k++) begin
         if (!w_sel_found && w_elig[r_ptr + 4'(k)]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = r_ptr + 4'(k);
         end
      end
   end

   // Selection is recomputed in S_ISSUE, so a source served the cycle before is never issued.
   always_comb begin
      w_state_next = r_state;
      w_valid      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (emergency)        w_state_next = S_HOLD;
            else if (w_sel_found) w_state_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_valid = w_sel_found;
            if (emergency)         w_state_next = S_HOLD;
            else if (!w_sel_found) w_state_next = S_IDLE;
            else if (ISSUE_GAP == 1) w_state_next = S_IDLE;
            else                   w_state_next = S_GAP;
         end
         S_GAP: begin
            if (emergency)          w_state_next = S_HOLD;
            else if (r_cnt <= CW'(1)) w_state_next = S_IDLE;
         end
         S_HOLD: begin
            if (!emergency) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_set = w_valid ? (N_SRC'(1) << w_sel_idx) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_up_prev   <= '0;
         r_dn_prev   <= '0;
         r_pend      <= '0;
         r_issued    <= '0;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_req_floor <= '0;
         r_dir       <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_up_prev <= hall_up_btn;
         r_dn_prev <= hall_down_btn;
         r_pend    <= (r_pend | {w_press_dn, w_press_up}) & ~w_clear;
         if (r_state == S_HOLD) r_issued <= '0;
         else                   r_issued <= (r_issued | w_set) & ~w_clear;
         if (w_valid) begin
            r_ptr       <= w_sel_idx + 4'd1;
            r_cnt       <= CW'(ISSUE_GAP - 1);
            r_req_floor <= w_sel_idx[2:0];
            r_dir       <= ~w_sel_idx[3];
         end else if (r_state == S_GAP && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign car_if.valid_out = w_valid;
   assign car_if.req_floor = w_valid ? w_sel_idx[2:0] : r_req_floor;
   assign car_if.direction = w_valid ? ~w_sel_idx[3]  : r_dir;

   assign pending_up   = r_pend[NUM_FLOORS-1:0];
   assign pending_down = r_pend[N_SRC-1:NUM_FLOORS];
   assign busy         = |r_pend;

endmodule

// File: tb/tb_hall_call_scheduler.sv
// Directed bench for hall_call_scheduler: capture, round-robin order, spacing,
// service clear, ignored buttons, emergency hold/re-issue and async reset.
module tb_hall_call_scheduler;

   logic       clk;
   logic       reset_n;
   logic [7:0] hall_up_btn;
   logic [7:0] hall_down_btn;
   logic       emergency;
   logic [7:0] pending_up;
   logic [7:0] pending_down;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   hall_call_scheduler_if car_if ();

   hall_call_scheduler #(.NUM_FLOORS(8), .ISSUE_GAP(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .hall_up_btn  (hall_up_btn),
      .hall_down_btn(hall_down_btn),
      .emergency    (emergency),
      .pending_up   (pending_up),
      .pending_down (pending_down),
      .busy         (busy),
      .car_if       (car_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic count_strobes(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (car_if.valid_out === 1'b1) cnt++;
      end
   endtask

   task automatic do_reset();
      hall_up_btn       = '0;
      hall_down_btn     = '0;
      emergency         = 1'b0;
      car_if.car_floor  = 3'd0;
      car_if.door_open  = 1'b0;
      car_if.car_idle   = 1'b0;
      tick();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   initial begin : stim
      int n;
      int cyc [4];
      int flr [4];
      int dir [4];
      int found;
      int rf, rd;

      reset_n           = 1'b0;
      hall_up_btn       = '0;
      hall_down_btn     = '0;
      emergency         = 1'b0;
      car_if.car_floor  = 3'd0;
      car_if.door_open  = 1'b0;
      car_if.car_idle   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", car_if.valid_out, 0);
      chk("rst_req",   car_if.req_floor, 0);
      chk("rst_dir",   car_if.direction, 0);
      chk("rst_pup",   pending_up, 0);
      chk("rst_pdn",   pending_down, 0);
      chk("rst_busy",  busy, 0);
      reset_n = 1'b1;
      tick();

      // Single up call at floor 5, button held throughout
      hall_up_btn = 8'h20;
      tick();
      chk("t1_pup",   pending_up, 8'h20);
      chk("t1_busy",  busy, 1);
      chk("t1_nov",   car_if.valid_out, 0);
      tick();
      chk("t1_valid", car_if.valid_out, 1);
      chk("t1_req",   car_if.req_floor, 5);
      chk("t1_dir",   car_if.direction, 1);
      count_strobes(10, n);
      chk("t1_held_nostrobe", n, 0);
      chk("t1_pup_kept", pending_up, 8'h20);
      car_if.car_floor = 3'd5;
      car_if.car_idle  = 1'b1;
      tick();
      chk("t1_clr_pup",  pending_up, 0);
      chk("t1_clr_busy", busy, 0);
      car_if.car_idle  = 1'b0;
      car_if.car_floor = 3'd0;
      count_strobes(4, n);
      chk("t1_noretrig_strobe", n, 0);
      chk("t1_noretrig_pup", pending_up, 0);
      hall_up_btn = '0;

      // Three simultaneous calls, pointer at 0: up2, up4, down6, 5 cycles apart
      do_reset();
      hall_up_btn   = 8'h14;
      hall_down_btn = 8'h40;
      tick();
      hall_up_btn   = '0;
      hall_down_btn = '0;
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (car_if.valid_out === 1'b1 && n < 4) begin
            cyc[n] = c;
            flr[n] = int'(car_if.req_floor);
            dir[n] = int'(car_if.direction);
            n++;
         end
      end
      chk("t2_count", n, 3);
      chk("t2_cyc0", cyc[0], 1);
      chk("t2_cyc1", cyc[1], 6);
      chk("t2_cyc2", cyc[2], 11);
      chk("t2_flr0", flr[0], 2);
      chk("t2_flr1", flr[1], 4);
      chk("t2_flr2", flr[2], 6);
      chk("t2_dir0", dir[0], 1);
      chk("t2_dir1", dir[1], 1);
      chk("t2_dir2", dir[2], 0);

      // Serve an issued call with door open
      do_reset();
      hall_up_btn = 8'h08;
      tick();
      hall_up_btn = '0;
      tick();
      chk("t3_valid", car_if.valid_out, 1);
      chk("t3_req",   car_if.req_floor, 3);
      car_if.car_floor = 3'd3;
      car_if.door_open = 1'b1;
      tick();
      chk("t3_clr_pup",  pending_up, 0);
      chk("t3_clr_busy", busy, 0);
      car_if.door_open = 1'b0;
      car_if.car_floor = 3'd0;
      count_strobes(8, n);
      chk("t3_no_reissue", n, 0);

      // Nonexistent buttons are ignored
      hall_up_btn   = 8'h80;
      hall_down_btn = 8'h01;
      tick();
      chk("t4_pup",  pending_up, 0);
      chk("t4_pdn",  pending_down, 0);
      chk("t4_busy", busy, 0);
      hall_up_btn   = '0;
      hall_down_btn = '0;
      count_strobes(8, n);
      chk("t4_nostrobe", n, 0);

      // Emergency hold and re-issue of down4
      do_reset();
      hall_down_btn = 8'h10;
      tick();
      hall_down_btn = '0;
      tick();
      chk("t5_valid", car_if.valid_out, 1);
      chk("t5_req",   car_if.req_floor, 4);
      chk("t5_dir",   car_if.direction, 0);
      emergency = 1'b1;
      count_strobes(20, n);
      chk("t5_hold_nostrobe", n, 0);
      chk("t5_pdn_kept", pending_down, 8'h10);
      emergency = 1'b0;
      found = 0;
      rf = -1;
      rd = -1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (car_if.valid_out === 1'b1 && found == 0) begin
            found = 1;
            rf = int'(car_if.req_floor);
            rd = int'(car_if.direction);
         end
      end
      chk("t5_reissue", found, 1);
      chk("t5_re_req",  rf, 4);
      chk("t5_re_dir",  rd, 0);

      // Press at the floor being served: clear wins
      car_if.car_floor = 3'd2;
      car_if.car_idle  = 1'b1;
      hall_up_btn      = 8'h04;
      tick();
      chk("t6_pup",  pending_up, 0);
      chk("t6_busy", busy, 1);
      hall_up_btn = '0;
      count_strobes(8, n);
      chk("t6_nostrobe", n, 0);

      // Asynchronous reset mid-cycle with down4 still pending
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_ar_pdn",   pending_down, 0);
      chk("t6_ar_busy",  busy, 0);
      chk("t6_ar_valid", car_if.valid_out, 0);
      chk("t6_ar_req",   car_if.req_floor, 0);
      reset_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hall_call_scheduler.md
Name: hall_call_scheduler

Overview:
- Collects hall-call button presses from all 8 floors (up and down buttons) and latches them as pending requests.
- Serialises pending requests into the single-request port of the elevator car controller (valid/req_floor/direction), one at a time, using fair round-robin selection.
- Clears each request when the car serves that floor.
- Sits between the floor button panel and the elevator controller; freezes during emergency.

Parameters:
- NUM_FLOORS, 8, number of floors; fixed at 8 for this revision (3-bit floor codes).
- ISSUE_GAP, 4, idle cycles enforced after each issued request before the next issue (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- hall_up_btn  input  8  level, one per floor, synchronous to clk; bit 7 is ignored (no up call from top floor).
- hall_down_btn  input  8  level, one per floor; bit 0 is ignored (no down call from ground floor).
- emergency  input  1  level; suspends issuing.
- car_floor  input  3  current floor of the car.
- door_open  input  1  high while the car door is open at car_floor.
- car_idle  input  1  high while the car is idle (stationary, door closed).
- valid_out  output  1  one-cycle request strobe to the car controller.
- req_floor  output  3  floor of the issued request; held until the next issue.
- direction  output  1  1 = up call, 0 = down call; held with req_floor.
- pending_up  output  8  up-call lamps (latched pending bits).
- pending_down  output  8  down-call lamps.
- busy  output  1  OR of all pending bits.

Behaviour:
- Reset (async, reset_n=0) values:
  - valid_out=0, req_floor=0, direction=0.
  - pending_up=0, pending_down=0, busy=0.
  - issued bits=0, button history=0, rr pointer=0, gap counter=0, state=S_IDLE.
- Button capture:
  - A press is a rising edge: current sample 1, previous sample 0.
  - A held button does not re-trigger.
  - A press sets pending_x[f].
  - Presses on hall_up_btn[7] and hall_down_btn[0] are discarded.
- Sources: 16 indices. Index f (0..7) = up call at floor f; index 8+f = down call at floor f.
  - A source is eligible when pending=1 and issued=0.
- Service/clear:
  - Condition: (door_open | car_idle) & car_floor==f.
  - When it holds, clear pending_up[f], pending_down[f] and both issued bits at f, in that cycle.
  - If a press and a clear hit the same bit in the same cycle, clear wins; the floor is being served.
- State S_IDLE:
  - If emergency -> S_HOLD.
  - Else if any eligible source -> S_ISSUE, latching the first eligible index at or after the rr pointer, searching upward modulo 16.
- State S_ISSUE (one cycle):
  - valid_out=1; req_floor=selected floor.
  - direction=1 for an up source, 0 for a down source.
  - Set issued[selected]; rr pointer = (selected+1) mod 16.
  - Load gap counter = ISSUE_GAP-1, then -> S_GAP.
  - If emergency is high in this cycle, the issue is still completed and the next state is S_HOLD.
  - If the selected source was cleared in the previous cycle, selection is re-evaluated: no stale issue.
- State S_GAP:
  - Decrement the counter; when it reaches 0, -> S_IDLE.
  - emergency -> S_HOLD immediately.
- State S_HOLD:
  - valid_out=0; all issued bits cleared, so every pending call is re-issued after recovery.
  - Pending bits are retained and button capture continues.
  - Clear rule still applies.
  - On !emergency -> S_IDLE.
- valid_out is never high in two consecutive cycles; minimum spacing between strobes is ISSUE_GAP+1 cycles.
- busy is a registered/combinational OR of the pending bits, updated in the same cycle as the bits.
- Reset asserted mid-operation: all state returns to reset values immediately; outstanding pending calls are lost.

Test Plan:
- Reset, then press hall_up_btn[5] for one cycle with car_floor=0 and car idle elsewhere -> pending_up[5]=1, busy=1. Two cycles later valid_out=1 with req_floor=5, direction=1. No second strobe while the button stays held.
- Press up[2], down[6] and up[4] in the same cycle, pointer=0 -> issue order: up2, up4, down6 (indices 2, 4, 14). Strobes are exactly ISSUE_GAP+1=5 cycles apart.
- After up[3] is issued, drive car_floor=3 with door_open=1 -> pending_up[3] clears in that cycle. No re-issue; busy=0 if nothing else is pending.
- Press hall_down_btn[0] and hall_up_btn[7] -> no pending bits set, no strobe.
- Issue down[4], then assert emergency for 20 cycles -> no valid_out during that window. After deassert, down[4] is re-issued (req_floor=4, direction=0) within 2 cycles.
- Car idle at floor 2 with car_floor=2, press up[2] -> clear wins: pending_up[2] stays 0 and no strobe. Pulse reset_n low while requests are pending -> all outputs zero asynchronously.
